// File: rtl/dyser_link_pkg.sv
// Shared definitions for the DySER tile link: width helpers and error cause codes.
package dyser_link_pkg;

    // Causes of the sticky err flag; kept so checkers can name the violation.
    typedef enum logic [0:0] {
        FIFO_OVF   = 1'b0,
        CREDIT_OVF = 1'b1
    } err_cause_t;

    // Position of the valid bit inside a WIDTH+1 bit data word.
    function automatic int valid_bit(input int width);
        return width;
    endfunction

    // FIFO pointers carry one extra wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Counter wide enough to hold the value CREDITS itself.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    // Channel id width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// Single-channel FIFO with combinational head read, flush, full and empty.
module link_fifo
    import dyser_link_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             do_push, do_pop;

    // Equal pointers mean empty; same index with differing wrap bit means full.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so a grant can forward it in the same cycle.
    assign rdata = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update: flush wins over any push or pop.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tile_link_mux.sv
// Concentrates NUM_CH credit-flow-controlled channels onto one shared link.
module tile_link_mux
    import dyser_link_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*(WIDTH+1)-1:0]   d_in,
    output logic [NUM_CH-1:0]             c_out,
    output logic [WIDTH:0]                d_out,
    output logic [ch_width(NUM_CH)-1:0]   ch_out,
    input  logic [NUM_CH-1:0]             c_in,
    input  logic                          conf_en,
    output logic                          err
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CR_W  = credit_width(CREDITS);
    localparam int SLICE = WIDTH + 1;
    localparam int VB    = valid_bit(WIDTH);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);

    logic [NUM_CH-1:0] push_req, fifo_full, fifo_empty, eligible, grant;
    logic [NUM_CH-1:0] fifo_ovf, cr_ovf;
    logic [WIDTH-1:0]  fifo_rdata [NUM_CH];

    logic [CH_W-1:0]   ptr_reg, ptr_next;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W:0]     arb_idx;
    logic              grant_any;

    logic [WIDTH:0]    d_out_reg;
    logic [CH_W-1:0]   ch_out_reg;
    logic [NUM_CH-1:0] c_out_reg;
    logic              err_reg, err_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CR_W-1:0] credit_reg, credit_next;
            logic            ovf;

            // Pushes are ignored entirely while the tile is being reconfigured.
            assign push_req[gi] = d_in[gi*SLICE + VB] && !conf_en;
            assign fifo_ovf[gi] = push_req[gi] && fifo_full[gi] && !grant[gi];
            assign eligible[gi] = !fifo_empty[gi] && (credit_reg != '0);
            assign cr_ovf[gi]   = ovf;

            link_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (conf_en),
                .push  (push_req[gi]),
                .pop   (grant[gi]),
                .wdata (d_in[gi*SLICE +: WIDTH]),
                .rdata (fifo_rdata[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi])
            );

            // Credit bookkeeping: returned credit and a grant in one cycle cancel out.
            always_comb begin
                credit_next = credit_reg;
                ovf         = 1'b0;
                if (conf_en) begin
                    credit_next = CR_MAX;
                end else if (c_in[gi] && !grant[gi]) begin
                    if (credit_reg == CR_MAX) ovf = 1'b1;
                    else                      credit_next = credit_reg + CR_W'(1);
                end else if (grant[gi] && !c_in[gi]) begin
                    credit_next = credit_reg - CR_W'(1);
                end
            end

            // Credit register, full at reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) credit_reg <= CR_MAX;
                else        credit_reg <= credit_next;
            end
        end
    endgenerate

    // Round-robin search starting at ptr_reg; first eligible channel wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        arb_idx   = '0;
        if (!conf_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                arb_idx = {1'b0, ptr_reg} + (CH_W+1)'(i);
                if (arb_idx >= (CH_W+1)'(NUM_CH)) arb_idx = arb_idx - (CH_W+1)'(NUM_CH);
                if (!grant_any && eligible[arb_idx[CH_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = arb_idx[CH_W-1:0];
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // Pointer moves past the winner, holds when idle, clears on reconfiguration.
    always_comb begin
        ptr_next = ptr_reg;
        if (conf_en) begin
            ptr_next = '0;
        end else if (grant_any) begin
            ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // Sticky error collects FIFO overflow and credit overflow from every channel.
    always_comb begin
        err_next = err_reg | (|fifo_ovf) | (|cr_ovf);
    end

    // Link output, credit-return pulse, arbiter pointer and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_reg  <= '0;
            ch_out_reg <= '0;
            c_out_reg  <= '0;
            err_reg    <= 1'b0;
            ptr_reg    <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            c_out_reg <= grant;
            err_reg   <= err_next;
            if (grant_any) begin
                d_out_reg  <= {1'b1, fifo_rdata[grant_idx]};
                ch_out_reg <= grant_idx;
            end else begin
                // Idle cycle: only the valid bit drops, payload and id hold.
                d_out_reg[VB] <= 1'b0;
            end
        end
    end

    assign d_out  = d_out_reg;
    assign ch_out = ch_out_reg;
    assign c_out  = c_out_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_tile_link_mux.sv
// Directed testbench for tile_link_mux with hand-computed expectations.
module tb_tile_link_mux;

    localparam int WIDTH   = 32;
    localparam int NUM_CH  = 4;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 2;

    logic                        clk     = 1'b0;
    logic                        rst_n   = 1'b0;
    logic [NUM_CH*(WIDTH+1)-1:0] d_in    = '0;
    logic [NUM_CH-1:0]           c_in    = '0;
    logic                        conf_en = 1'b0;
    logic [NUM_CH-1:0]           c_out;
    logic [WIDTH:0]              d_out;
    logic [1:0]                  ch_out;
    logic                        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data [$];
    logic [1:0]  got_ch   [$];

    always #5 clk = ~clk;

    tile_link_mux #(
        .WIDTH   (WIDTH),
        .NUM_CH  (NUM_CH),
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .c_out   (c_out),
        .d_out   (d_out),
        .ch_out  (ch_out),
        .c_in    (c_in),
        .conf_en (conf_en),
        .err     (err)
    );

    // Link monitor: one line per transferred word.
    always @(posedge clk) begin
        #1;
        if (rst_n && d_out[WIDTH]) begin
            got_data.push_back(d_out[WIDTH-1:0]);
            got_ch.push_back(ch_out);
            $display("xfer t=%0t ch=%0d data=%h", $time, ch_out, d_out[WIDTH-1:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [31:0] data);
        d_in[k*(WIDTH+1) +: (WIDTH+1)] = {1'b1, data};
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        d_in    = '0;
        c_in    = '0;
        conf_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        got_data.delete();
        got_ch.delete();
    endtask

    // Pushes two words on channel k and lets them leave, leaving credit[k] at 0.
    task automatic drain_credit(input int k);
        drive(k, 32'hDEAD_0000);
        step();
        drive(k, 32'hDEAD_0001);
        step();
        d_in = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (d_out !== '0)  begin errors++; $display("FAIL reset_d_out: got %h want 0", d_out); end
        checks++; if (ch_out !== '0) begin errors++; $display("FAIL reset_ch_out: got %0d want 0", ch_out); end
        checks++; if (c_out !== '0)  begin errors++; $display("FAIL reset_c_out: got %b want 0", c_out); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        drive(2, 32'h0000_00A5);
        step();
        d_in = '0;
        checks++; if (d_out[WIDTH] !== 1'b0) begin errors++; $display("FAIL single_early: valid %b want 0", d_out[WIDTH]); end
        step();
        checks++; if (d_out !== {1'b1, 32'h0000_00A5}) begin errors++; $display("FAIL single_data: got %h want 1000000a5", d_out); end
        checks++; if (ch_out !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d want 2", ch_out); end
        checks++; if (c_out !== 4'b0100) begin errors++; $display("FAIL single_c_out: got %b want 0100", c_out); end
        step();
        checks++; if (c_out !== 4'b0000) begin errors++; $display("FAIL single_c_out_once: got %b want 0000", c_out); end
        checks++; if (d_out[WIDTH] !== 1'b0) begin errors++; $display("FAIL single_idle: valid %b want 0", d_out[WIDTH]); end
        // credit[2] is now 1: of two more words only one may leave
        got_data.delete();
        got_ch.delete();
        drive(2, 32'h0000_00B1);
        step();
        drive(2, 32'h0000_00B2);
        step();
        d_in = '0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL single_credit_left: got %0d words want 1", got_data.size()); end
        c_in = 4'b0100;
        step();
        c_in = '0;
        step();
        checks++; if (d_out !== {1'b1, 32'h0000_00B2}) begin errors++; $display("FAIL single_after_cin: got %h want 1000000b2", d_out); end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_d;
        logic [1:0]  exp_c;
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            d_in = '0;
            if (cyc < 3) begin
                for (int k = 0; k < NUM_CH; k++) drive(k, 32'hC000_0000 | (k << 8) | cyc);
            end
            // downstream returns one credit for each word it sees
            c_in = d_out[WIDTH] ? (4'b0001 << ch_out) : 4'b0000;
            step();
        end
        d_in = '0;
        c_in = '0;
        checks++; if (got_data.size() !== 12) begin errors++; $display("FAIL fair_count: got %0d words want 12", got_data.size()); end
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            exp_c = 2'(i % 4);
            exp_d = 32'hC000_0000 | ((i % 4) << 8) | (i / 4);
            checks++;
            if (got_ch[i] !== exp_c || got_data[i] !== exp_d) begin
                errors++;
                $display("FAIL fair_order[%0d]: got ch%0d %h want ch%0d %h", i, got_ch[i], got_data[i], exp_c, exp_d);
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fair_err: got %b want 0", err); end
    endtask

    task automatic test_credit_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0000_5000 + i);
            step();
        end
        d_in = '0;
        for (int i = 0; i < 8; i++) step();
        checks++; if (got_data.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d words want 2", got_data.size()); end
        c_in = 4'b0001;
        step();
        c_in = '0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (got_data.size() !== 3) begin errors++; $display("FAIL stall_release: got %0d words want 3", got_data.size()); end
        if (got_data.size() >= 3) begin
            checks++; if (got_data[2] !== 32'h0000_5002) begin errors++; $display("FAIL stall_word: got %h want 00005002", got_data[2]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drain_credit(1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h0000_7000 + i);
            step();
            if (i == 3) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_early: err %b want 0", err); end
            end
        end
        d_in = '0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: err %b want 1", err); end
        for (int i = 0; i < 4; i++) begin
            c_in = 4'b0010;
            step();
            c_in = '0;
            step();
            checks++;
            if (d_out !== {1'b1, 32'h0000_7000 + 32'(i)}) begin
                errors++;
                $display("FAIL ovf_word[%0d]: got %h want %h", i, d_out, {1'b1, 32'h0000_7000 + 32'(i)});
            end
        end
        c_in = 4'b0010;
        step();
        c_in = '0;
        step();
        checks++; if (d_out[WIDTH] !== 1'b0) begin errors++; $display("FAIL ovf_dropped: valid %b data %h want no word", d_out[WIDTH], d_out); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: err %b want 1", err); end
    endtask

    task automatic test_simultaneous();
        // credit return in the same cycle as a grant leaves the count at 2
        do_reset();
        drive(0, 32'h0000_1111);
        step();
        d_in = '0;
        c_in = 4'b0001;
        step();
        c_in = '0;
        checks++; if (d_out !== {1'b1, 32'h0000_1111}) begin errors++; $display("FAIL simul_grant: got %h want 100001111", d_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_cin_err: err %b want 0", err); end
        step();
        got_data.delete();
        got_ch.delete();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0000_2220 + i);
            step();
        end
        d_in = '0;
        for (int i = 0; i < 8; i++) step();
        checks++; if (got_data.size() !== 2) begin errors++; $display("FAIL simul_credit: got %0d words want 2", got_data.size()); end

        // push into a full FIFO together with a pop
        do_reset();
        drain_credit(3);
        for (int i = 0; i < 4; i++) begin
            drive(3, 32'h0000_3300 + i);
            step();
        end
        d_in = '0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_fill_err: err %b want 0", err); end
        c_in = 4'b1000;
        step();
        c_in = '0;
        drive(3, 32'h0000_3304);
        step();
        d_in = '0;
        checks++; if (d_out !== {1'b1, 32'h0000_3300} || ch_out !== 2'd3) begin errors++; $display("FAIL simul_pop: got ch%0d %h want ch3 100003300", ch_out, d_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_pushpop_err: err %b want 0", err); end
        for (int i = 1; i < 5; i++) begin
            c_in = 4'b1000;
            step();
            c_in = '0;
            step();
            checks++;
            if (d_out !== {1'b1, 32'h0000_3300 + 32'(i)}) begin
                errors++;
                $display("FAIL simul_word[%0d]: got %h want %h", i, d_out, {1'b1, 32'h0000_3300 + 32'(i)});
            end
        end
        c_in = 4'b1000;
        step();
        c_in = '0;
        step();
        checks++; if (d_out[WIDTH] !== 1'b0) begin errors++; $display("FAIL simul_occupancy: valid %b data %h want no fifth word", d_out[WIDTH], d_out); end
    endtask

    task automatic test_flush();
        logic [NUM_CH-1:0] seen_cout;
        do_reset();
        drain_credit(1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_4400 + i);
            step();
        end
        d_in = '0;
        step();
        got_data.delete();
        got_ch.delete();
        conf_en = 1'b1;
        c_in    = 4'b0010;
        drive(2, 32'h0000_4499);
        step();
        conf_en = 1'b0;
        c_in    = '0;
        d_in    = '0;
        checks++; if (d_out[WIDTH] !== 1'b0) begin errors++; $display("FAIL flush_valid: valid %b want 0", d_out[WIDTH]); end
        checks++; if (c_out !== 4'b0000) begin errors++; $display("FAIL flush_c_out: got %b want 0000", c_out); end
        seen_cout = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_cout = seen_cout | c_out;
        end
        checks++; if (seen_cout !== 4'b0000) begin errors++; $display("FAIL flush_no_credit: c_out seen %b want 0000", seen_cout); end
        checks++; if (got_data.size() !== 0) begin errors++; $display("FAIL flush_empty: got %0d words want 0", got_data.size()); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_4410 + i);
            step();
        end
        d_in = '0;
        for (int i = 0; i < 8; i++) step();
        checks++; if (got_data.size() !== 2) begin errors++; $display("FAIL flush_reload: got %0d words want 2", got_data.size()); end
        if (got_data.size() >= 2) begin
            checks++;
            if (got_data[0] !== 32'h0000_4410 || got_data[1] !== 32'h0000_4411 || got_ch[0] !== 2'd1 || got_ch[1] !== 2'd1) begin
                errors++;
                $display("FAIL flush_words: got ch%0d %h ch%0d %h want ch1 00004410 ch1 00004411", got_ch[0], got_data[0], got_ch[1], got_data[1]);
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: err %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        c_in = 4'b0100;
        step();
        c_in = '0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL credit_ovf_err: err %b want 1", err); end
        drive(0, 32'h0000_9990);
        drive(1, 32'h0000_9991);
        step();
        d_in = '0;
        step();
        step();
        checks++; if (d_out !== {1'b1, 32'h0000_9991} || ch_out !== 2'd1) begin errors++; $display("FAIL mid_pre: got ch%0d %h want ch1 100009991", ch_out, d_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (d_out !== '0)  begin errors++; $display("FAIL mid_d_out: got %h want 0", d_out); end
        checks++; if (ch_out !== '0) begin errors++; $display("FAIL mid_ch_out: got %0d want 0", ch_out); end
        checks++; if (c_out !== '0)  begin errors++; $display("FAIL mid_c_out: got %b want 0", c_out); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL mid_err: got %b want 0", err); end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_stall();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_link_mux.md
# tile_link_mux

Parametrised multi-channel credit link for the DySER fabric: it concentrates NUM_CH credit-flow-controlled tile data channels onto one shared physical link toward a neighbouring tile.
- Per-channel input FIFOs return credits upstream.
- Per-channel downstream credit counters gate transmission.
- A round-robin arbiter picks one eligible channel per cycle.
- conf_en flushes the block, as a tile does on reconfiguration.

## Interface
Parameters:
- WIDTH, 32, payload bits; every data port is WIDTH+1 bits, bit WIDTH = valid.
- NUM_CH, 4, logical channels (≥2).
- DEPTH, 4, entries per input FIFO (power of two, ≥2).
- CREDITS, 2, downstream buffer depth per channel (1..15).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- d_in  in  NUM_CH*(WIDTH+1)  upstream data, channel k at slice k; valid at MSB of each slice.
- c_out  out  NUM_CH  one-cycle credit return per channel to upstream.
- d_out  out  WIDTH+1  shared link data; bit WIDTH = valid.
- ch_out  out  max(1,$clog2(NUM_CH))  channel id of d_out, meaningful only when valid.
- c_in  in  NUM_CH  one-cycle credit pulses from downstream per channel.
- conf_en  in  1  configuration phase: flush FIFOs and reload credits.
- err  out  1  sticky protocol-violation flag.

## Operation
- Write: a channel slice with valid=1 is pushed into its FIFO at the clock edge.
- Push into a full FIFO: the data is dropped, err is set and stays set until reset. FIFO state is unchanged.
- Eligibility: channel k is eligible when its FIFO is non-empty and credit[k] > 0.
- Arbitration: round robin. Pointer p resets to 0. The first eligible channel searching p, p+1, … wrapping modulo NUM_CH is granted. After a grant to k, p = (k+1) mod NUM_CH. With no grant, p is held.
- Grant: the head entry of the granted FIFO is popped and loaded into the d_out/ch_out register. credit[k] decrements. c_out[k] pulses in the next cycle.
- No grant: the d_out valid bit is registered 0. Payload and ch_out hold their previous value.
- Credit counter per channel, width $clog2(CREDITS+1):
  - reset value = CREDITS;
  - c_in[k] without a grant to k: +1;
  - grant to k without c_in[k]: −1;
  - both in the same cycle: unchanged;
  - c_in[k] while credit[k] = CREDITS: counter saturates and err is set.
- Same-cycle push and pop on one FIFO is legal, also when the FIFO is full: the pop frees the slot and no error is raised.
- conf_en=1, evaluated each cycle:
  - all FIFOs are emptied and credits reload to CREDITS;
  - p returns to 0 and the d_out valid bit is 0;
  - no grants occur and d_in pushes are ignored;
  - c_out stays 0, with no credits returned for flushed entries;
  - err is unaffected.
- FIFO pointers are clog2(DEPTH)+1 bits. Full/empty is decided by the MSB-differ/equal rule, with wrap-around at DEPTH.

## Timing
- Reset values: d_out = 0, ch_out = 0, c_out = 0, err = 0, credits = CREDITS, FIFOs empty, p = 0.
- Reset mid-operation clears all state immediately, regardless of clk.
- Latency: input valid at edge t (written) → d_out valid after edge t+1, provided the channel wins arbitration with credit. Minimum latency is 2 cycles from d_in presentation.
- c_out[k] is asserted for exactly one cycle, in the cycle after the pop edge. It asserts at most once per popped entry.
- Throughput: one word per cycle on the link. A single channel with CREDITS ≥ 2 and a downstream that returns credits within 1 cycle sustains full rate.
- A c_in pulse at edge t makes the channel eligible for arbitration at edge t+1.

## Structure
- Shared package dyser_link_pkg holds:
  - the valid-bit position helper;
  - the pointer-width and credit-width functions;
  - the err cause encodings (FIFO_OVF, CREDIT_OVF), kept for assertions.
- One sub-module: link_fifo, a single-channel DEPTH×(WIDTH) FIFO with push, pop, flush, full and empty. It is instantiated NUM_CH times via generate.
- The arbiter and credit counters stay inline in tile_link_mux.

## Test plan
- Single channel: push 0xA5 on ch2 with all credits full → d_out = {1,0xA5}, ch_out = 2, two edges later; c_out[2] pulses one cycle later; credit[2] = 1.
- Fairness: FIFOs 0..3 each hold 3 words, credits are unlimited by steady c_in → grant order 0,1,2,3,0,1,2,3,… with no channel skipped.
- Credit stall: CREDITS = 2, ch0 holds 4 words, no c_in → exactly 2 words sent, then d_out valid = 0. One c_in[0] pulse → exactly one more word sent.
- Overflow: 5 consecutive pushes on ch1 with DEPTH = 4 and no credit → err = 1 after the 5th edge; FIFO holds the first 4 words, delivered in order once credits arrive.
- Simultaneous events: c_in[0] together with a grant to ch0 → credit unchanged. A push into a full FIFO together with a pop → no err, occupancy stays 4.
- Flush and reset: conf_en for 1 cycle with words pending → no output, no c_out, credits = CREDITS. Deasserting rst_n mid-transfer → all outputs 0 immediately.
